// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and the future receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS_MIN  = 5;
    // Longest frame: start + 8 data + parity + 2 stop.
    localparam int unsigned FRAME_BITS_MAX = 12;
    localparam int unsigned BIT_CNT_WIDTH  = $clog2(FRAME_BITS_MAX + 1);

    typedef enum logic [1:0] {
        PARITY_NONE     = 2'd0,
        PARITY_EVEN     = 2'd1,
        PARITY_ODD      = 2'd2,
        PARITY_NONE_ALT = 2'd3
    } parity_t;

    // Encoded as data length minus five.
    typedef enum logic [1:0] {
        DATA_BITS_5 = 2'd0,
        DATA_BITS_6 = 2'd1,
        DATA_BITS_7 = 2'd2,
        DATA_BITS_8 = 2'd3
    } data_bits_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    function automatic logic [7:0] data_mask(input data_bits_t len);
        logic [7:0] mask;
        case (len)
            DATA_BITS_5: mask = 8'h1F;
            DATA_BITS_6: mask = 8'h3F;
            DATA_BITS_7: mask = 8'h7F;
            default:     mask = 8'hFF;
        endcase
        return mask;
    endfunction

    function automatic logic parity_bit(input logic [7:0] d, input data_bits_t len,
                                        input parity_t mode);
        logic [7:0] masked;
        masked = d & data_mask(len);
        return (^masked) ^ (mode == PARITY_ODD);
    endfunction

    function automatic logic parity_enabled(input parity_t mode);
        return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO of 2^LOG2 words with an occupancy output.
module uart_fifo #(
    parameter int unsigned LOG2 = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [LOG2:0] level,
    output logic          empty,
    output logic          full
);

    localparam int unsigned DEPTH = 1 << LOG2;

    logic [7:0]      mem [DEPTH];
    logic [LOG2-1:0] wr_ptr;
    logic [LOG2-1:0] rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Level never exceeds DEPTH, so its top bit alone flags full.
    assign full    = level[LOG2];
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; reset flushes the queue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: input FIFO, per-frame configuration latch, bit timing.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned FREQUENCY = 50000000,
    parameter int unsigned BPS       = 115200,
    parameter int unsigned DIV_WIDTH = 20,
    parameter int unsigned FIFO_LOG2 = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [7:0]           data,
    input  logic                 valid,
    output logic                 ready,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic [1:0]           data_bits,
    input  logic [1:0]           parity,
    input  logic                 stop2,
    output logic                 serial_out,
    output logic                 busy,
    output logic [FIFO_LOG2:0]   fifo_level
);

    localparam int unsigned RESET_DIV = (FREQUENCY + BPS / 2) / BPS;

    uart_state_t              state;
    uart_state_t              state_next;
    logic                     push;
    logic                     pop;
    logic                     empty;
    logic                     full;
    logic [7:0]               head;
    logic                     line_next;
    logic [DIV_WIDTH-1:0]     div_eff;
    logic [DIV_WIDTH-1:0]     div_q;
    logic [DIV_WIDTH-1:0]     tick_cnt;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt;
    logic [BIT_CNT_WIDTH-1:0] data_last;
    logic [7:0]               shift_q;
    data_bits_t               len_q;
    logic                     par_en_q;
    logic                     par_bit_q;
    logic                     stop2_q;
    logic                     bit_done;
    logic                     last_data;
    logic                     last_stop;

    assign push  = valid & ready;
    assign ready = ~full;
    assign busy  = (state != ST_IDLE) | ~empty;

    uart_fifo #(
        .LOG2(FIFO_LOG2)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (data),
        .pop       (pop),
        .head      (head),
        .level     (fifo_level),
        .empty     (empty),
        .full      (full)
    );

    assign bit_done  = (tick_cnt == '0);
    assign data_last = BIT_CNT_WIDTH'(int'(len_q) + int'(DATA_BITS_MIN) - 1);
    assign last_data = (bit_cnt == data_last);
    assign last_stop = (bit_cnt == {{(BIT_CNT_WIDTH-1){1'b0}}, stop2_q});

    // Map the runtime divisor: 0 selects the reset baud, 1 is clamped to 2.
    always_comb begin
        div_eff = divisor;
        if (divisor == '0) begin
            div_eff = DIV_WIDTH'(RESET_DIV);
        end else if (divisor == DIV_WIDTH'(1)) begin
            div_eff = DIV_WIDTH'(2);
        end
    end

    // Next state, FIFO pop and line level for the current state.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        line_next  = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                line_next = 1'b0;
                if (bit_done) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                line_next = shift_q[0];
                if (bit_done && last_data) begin
                    state_next = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                line_next = par_bit_q;
                if (bit_done) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                line_next = 1'b1;
                if (bit_done && last_stop) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame datapath: configuration latched on pop, then bit and tick counting.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= '0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            len_q     <= DATA_BITS_8;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else if (pop) begin
            div_q     <= div_eff;
            tick_cnt  <= div_eff - 1'b1;
            bit_cnt   <= '0;
            shift_q   <= head;
            len_q     <= data_bits_t'(data_bits);
            par_en_q  <= parity_enabled(parity_t'(parity));
            par_bit_q <= parity_bit(head, data_bits_t'(data_bits), parity_t'(parity));
            stop2_q   <= stop2;
        end else if (state != ST_IDLE) begin
            if (bit_done) begin
                tick_cnt <= div_q - 1'b1;
                if (state_next != state) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (state == ST_DATA) begin
                    shift_q <= shift_q >> 1;
                end
            end else begin
                tick_cnt <= tick_cnt - 1'b1;
            end
        end
    end

    // Registered line output; the one-cycle delay keeps serial_out glitch-free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            serial_out <= 1'b1;
        end else begin
            serial_out <= line_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx against a bit-list frame model.
module tb_uart_tx;

    localparam int RESET_DIV = (50000000 + 115200 / 2) / 115200;

    logic        clock;
    logic        reset_n;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic [19:0] divisor;
    logic [1:0]  data_bits;
    logic [1:0]  parity;
    logic        stop2;
    logic        serial_out;
    logic        busy;
    logic [2:0]  fifo_level;

    int tests = 0;
    int fails = 0;
    bit cap[$];
    bit expw[$];

    uart_tx #(
        .FREQUENCY(50000000),
        .BPS      (115200),
        .DIV_WIDTH(20),
        .FIFO_LOG2(2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .divisor    (divisor),
        .data_bits  (data_bits),
        .parity     (parity),
        .stop2      (stop2),
        .serial_out (serial_out),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    // Appends one frame's per-cycle line levels to expw.
    task automatic model_frame(input logic [7:0] d, input int nb_code, input int par,
                               input bit s2, input int div);
        int n;
        int ediv;
        int ones;
        bit bits[$];
        n    = nb_code + 5;
        ediv = (div == 0) ? RESET_DIV : ((div == 1) ? 2 : div);
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par == 1) bits.push_back(bit'(ones % 2));
        else if (par == 2) bits.push_back(bit'(1 - ones % 2));
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[k]) repeat (ediv) expw.push_back(bits[k]);
    endtask

    task automatic capture(input int n);
        cap.delete();
        repeat (n) begin
            @(negedge clock);
            cap.push_back(serial_out);
        end
    endtask

    // Push one word; returns just after the accepting edge.
    task automatic push_word(input logic [7:0] d);
        @(negedge clock);
        data  = d;
        valid = 1'b1;
        @(negedge clock);
        valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        tests++; if (serial_out !== 1'b1) begin fails++; $display("FAIL reset_serial_out: got %b want 1", serial_out); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_8n1();
        int mis;
        divisor = 20'd4; data_bits = 2'd3; parity = 2'd0; stop2 = 1'b0;
        push_word(8'h55);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL 8n1_busy_start: got %b want 1", busy); end
        expw.delete();
        expw.push_back(1'b1);
        model_frame(8'h55, 3, 0, 1'b0, 4);
        expw.push_back(1'b1); expw.push_back(1'b1);
        capture(expw.size());
        mis = -1;
        foreach (expw[i]) if (mis < 0 && cap[i] !== expw[i]) mis = i;
        tests++; if (mis >= 0) begin fails++; $display("FAIL 8n1_wave: cycle %0d got %b want %b", mis, cap[mis], expw[mis]); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL 8n1_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_7e2();
        int mis;
        bit seq[11] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1};
        divisor = 20'd3; data_bits = 2'd2; parity = 2'd1; stop2 = 1'b1;
        push_word(8'h41);
        expw.delete();
        expw.push_back(1'b1);
        foreach (seq[k]) repeat (3) expw.push_back(seq[k]);
        expw.push_back(1'b1); expw.push_back(1'b1);
        capture(expw.size());
        mis = -1;
        foreach (expw[i]) if (mis < 0 && cap[i] !== expw[i]) mis = i;
        tests++; if (mis >= 0) begin fails++; $display("FAIL 7e2_wave: cycle %0d got %b want %b", mis, cap[mis], expw[mis]); end
    endtask

    task automatic test_5o1();
        int mis;
        bit seq[8] = '{0, 1, 1, 1, 1, 1, 0, 1};
        logic [7:0] words[2] = '{8'h1F, 8'hFF};
        divisor = 20'd2; data_bits = 2'd0; parity = 2'd2; stop2 = 1'b0;
        foreach (words[w]) begin
            push_word(words[w]);
            expw.delete();
            expw.push_back(1'b1);
            foreach (seq[k]) repeat (2) expw.push_back(seq[k]);
            expw.push_back(1'b1); expw.push_back(1'b1);
            capture(expw.size());
            mis = -1;
            foreach (expw[i]) if (mis < 0 && cap[i] !== expw[i]) mis = i;
            tests++; if (mis >= 0) begin fails++; $display("FAIL 5o1_wave_%h: cycle %0d got %b want %b", words[w], mis, cap[mis], expw[mis]); end
        end
    endtask

    task automatic test_back_to_back();
        int mis;
        int accepted;
        logic [7:0] w[6];
        bit acc[6];
        divisor = 20'd16; data_bits = 2'd3; parity = 2'd0; stop2 = 1'b0;
        foreach (w[i]) w[i] = 8'($urandom);
        push_word(w[0]);
        expw.delete();
        expw.push_back(1'b1);
        for (int i = 0; i < 5; i++) model_frame(w[i], 3, 0, 1'b0, 16);
        expw.push_back(1'b1); expw.push_back(1'b1);
        fork
            capture(expw.size());
            begin
                repeat (3) @(negedge clock);
                for (int i = 1; i <= 5; i++) begin
                    data   = w[i];
                    valid  = 1'b1;
                    acc[i] = ready;
                    @(negedge clock);
                end
                valid = 1'b0;
                accepted = 0;
                for (int i = 1; i <= 5; i++) accepted += int'(acc[i]);
                tests++; if (accepted !== 4) begin fails++; $display("FAIL b2b_accepted: got %0d want 4", accepted); end
                tests++; if (acc[5] !== 1'b0) begin fails++; $display("FAIL b2b_fifth_ready: got %b want 0", acc[5]); end
                tests++; if (ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_full: got %b want 0", ready); end
                tests++; if (fifo_level !== 3'd4) begin fails++; $display("FAIL b2b_level: got %0d want 4", fifo_level); end
            end
        join
        mis = -1;
        foreach (expw[i]) if (mis < 0 && cap[i] !== expw[i]) mis = i;
        tests++; if (mis >= 0) begin fails++; $display("FAIL b2b_wave: cycle %0d got %b want %b", mis, cap[mis], expw[mis]); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_divisor_change();
        int mis;
        logic [7:0] a;
        logic [7:0] b;
        a = 8'($urandom);
        b = 8'($urandom);
        divisor = 20'd4; data_bits = 2'd3; parity = 2'd0; stop2 = 1'b0;
        @(negedge clock);
        data = a; valid = 1'b1;
        @(negedge clock);
        data = b;
        @(negedge clock);
        valid = 1'b0;
        tests++; if (fifo_level !== 3'd1) begin fails++; $display("FAIL divchg_push_pop_level: got %0d want 1", fifo_level); end
        divisor = 20'd8;
        expw.delete();
        model_frame(a, 3, 0, 1'b0, 4);
        model_frame(b, 3, 0, 1'b0, 8);
        expw.push_back(1'b1); expw.push_back(1'b1);
        capture(expw.size());
        mis = -1;
        foreach (expw[i]) if (mis < 0 && cap[i] !== expw[i]) mis = i;
        tests++; if (mis >= 0) begin fails++; $display("FAIL divchg_wave: cycle %0d got %b want %b", mis, cap[mis], expw[mis]); end
    endtask

    task automatic test_divisor_special();
        int mis;
        int divs[2] = '{0, 1};
        logic [7:0] d;
        foreach (divs[j]) begin
            d = 8'($urandom);
            divisor = 20'(divs[j]); data_bits = 2'd0; parity = 2'd0; stop2 = 1'b0;
            push_word(d);
            expw.delete();
            expw.push_back(1'b1);
            model_frame(d, 0, 0, 1'b0, divs[j]);
            expw.push_back(1'b1); expw.push_back(1'b1);
            capture(expw.size());
            mis = -1;
            foreach (expw[i]) if (mis < 0 && cap[i] !== expw[i]) mis = i;
            tests++; if (mis >= 0) begin fails++; $display("FAIL divisor_%0d_wave: cycle %0d got %b want %b", divs[j], mis, cap[mis], expw[mis]); end
        end
    endtask

    task automatic test_random();
        int mis;
        int nb;
        int par;
        int dv;
        bit s2;
        logic [7:0] d;
        for (int it = 0; it < 12; it++) begin
            d   = 8'($urandom);
            nb  = int'($urandom_range(3, 0));
            par = int'($urandom_range(3, 0));
            s2  = bit'($urandom_range(1, 0));
            dv  = int'($urandom_range(7, 1));
            divisor = 20'(dv); data_bits = 2'(nb); parity = 2'(par); stop2 = s2;
            push_word(d);
            @(negedge clock);
            tests++; if (serial_out !== 1'b1) begin fails++; $display("FAIL rand%0d_latency: got %b want 1", it, serial_out); end
            // Scramble configuration once the frame has started.
            divisor = 20'($urandom_range(7, 1)); data_bits = 2'($urandom);
            parity = 2'($urandom); stop2 = 1'($urandom);
            expw.delete();
            model_frame(d, nb, par, s2, dv);
            expw.push_back(1'b1); expw.push_back(1'b1);
            capture(expw.size());
            mis = -1;
            foreach (expw[i]) if (mis < 0 && cap[i] !== expw[i]) mis = i;
            tests++; if (mis >= 0) begin fails++; $display("FAIL rand%0d_wave: d=%h nb=%0d par=%0d s2=%0d div=%0d cycle %0d got %b want %b", it, d, nb, par, s2, dv, mis, cap[mis], expw[mis]); end
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rand%0d_busy_end: got %b want 0", it, busy); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int mis;
        divisor = 20'd4; data_bits = 2'd3; parity = 2'd0; stop2 = 1'b0;
        @(negedge clock);
        data = 8'h00; valid = 1'b1;
        repeat (3) @(negedge clock);
        valid = 1'b0;
        tests++; if (fifo_level !== 3'd2) begin fails++; $display("FAIL rstmid_level_before: got %0d want 2", fifo_level); end
        repeat (8) @(negedge clock);
        tests++; if (serial_out !== 1'b0) begin fails++; $display("FAIL rstmid_line_before: got %b want 0", serial_out); end
        #2;
        reset_n = 1'b0;
        #1;
        tests++; if (serial_out !== 1'b1) begin fails++; $display("FAIL rstmid_serial_out: got %b want 1", serial_out); end
        tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL rstmid_level: got %0d want 0", fifo_level); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b want 1", ready); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        expw.delete();
        repeat (60) expw.push_back(1'b1);
        capture(expw.size());
        mis = -1;
        foreach (expw[i]) if (mis < 0 && cap[i] !== expw[i]) mis = i;
        tests++; if (mis >= 0) begin fails++; $display("FAIL rstmid_idle_after: cycle %0d got %b want %b", mis, cap[mis], expw[mis]); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy_after: got %b want 0", busy); end
    endtask

    initial begin
        valid     = 1'b0;
        data      = 8'h00;
        divisor   = 20'd4;
        data_bits = 2'd3;
        parity    = 2'd0;
        stop2     = 1'b0;
        test_reset();
        test_8n1();
        test_7e2();
        test_5o1();
        test_back_to_back();
        test_divisor_change();
        test_divisor_special();
        test_random();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter FREQUENCY, default 50000000, clock frequency in Hz.
REQ-002 Parameter BPS, default 115200, reset-default baud rate; RESET_DIV = (FREQUENCY + BPS/2)/BPS.
REQ-003 Parameter DIV_WIDTH, default 20, width of runtime divisor.
REQ-004 Parameter FIFO_LOG2, default 2, FIFO depth = 2^FIFO_LOG2 words.
REQ-005 clock  input  1  single clock, all state on posedge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 data  input  8  word to send, LSB first; bits above data length ignored.
REQ-008 valid  input  1  producer offers data.
REQ-009 ready  output  1  FIFO not full; transfer when valid & ready at posedge.
REQ-010 divisor  input  DIV_WIDTH  clocks per bit; 0 selects RESET_DIV; values 1 treated as 2.
REQ-011 data_bits  input  2  data length minus 5 (0=5 .. 3=8).
REQ-012 parity  input  2  0 none, 1 even, 2 odd, 3 treated as none.
REQ-013 stop2  input  1  1 = two stop bits, 0 = one.
REQ-014 serial_out  output  1  line, idle high.
REQ-015 busy  output  1  frame in progress or FIFO non-empty.
REQ-016 fifo_level  output  FIFO_LOG2+1  words currently queued.

Function
REQ-017 FIFO SHALL accept a word on each cycle with valid & ready; ready = (fifo_level < 2^FIFO_LOG2).
REQ-018 Simultaneous push and pop SHALL leave fifo_level unchanged; no push SHALL occur when full, no pop when empty.
REQ-019 Transmit FSM states IDLE, START, DATA, PARITY, STOP; each non-IDLE bit lasts exactly the latched divisor cycles.
REQ-020 IDLE -> START when FIFO non-empty: pop word and latch divisor, data_bits, parity, stop2 in the same cycle; serial_out falls at the next edge.
REQ-021 Configuration inputs SHALL be sampled only at frame start; changes mid-frame SHALL not affect the current frame.
REQ-022 START drives 0; DATA drives data[0..n-1], n = data_bits+5; PARITY (only if enabled) drives XOR of the n bits (even) or its inverse (odd); STOP drives 1 for 1 or 2 bit periods.
REQ-023 STOP end with FIFO non-empty SHALL enter START directly (no idle gap); otherwise IDLE.
REQ-024 Word pushed into an empty FIFO while IDLE at edge t SHALL produce serial_out falling at edge t+2.
REQ-025 Bit counter and per-bit down-counter SHALL be sized from DIV_WIDTH and max frame (12 bits); no wrap within a frame.
REQ-026 busy SHALL be 0 only when FSM is IDLE and FIFO is empty.

Reset
REQ-027 reset_n low SHALL immediately force serial_out=1, ready=1, busy=0, fifo_level=0, FSM=IDLE, FIFO flushed.
REQ-028 Reset mid-frame SHALL abort the frame; after release, the first frame starts only from a new push.
REQ-029 Reset deassertion SHALL be used synchronously-released by the integrating top; block requires no cycles of warm-up.

Structure
REQ-030 Shared package uart_pkg SHALL hold parity encodings, FSM state enum and data_bits encoding, shared with future uart_rx.
REQ-031 FIFO SHALL be a sub-module uart_fifo (parameter LOG2, width 8, level output); FSM and bit timing in uart_tx.

Verification
REQ-032 divisor=4, 8N1, push 0x55 -> serial_out 0,1,0,1,0,1,0,1,0,1, each 4 cycles, 40 cycles total, then busy=0.
REQ-033 divisor=3, data_bits=2 (7 bits), even parity, stop2=1, push 0x41 -> 0,1,0,0,0,0,0,1,0,1,1, each 3 cycles (parity 0).
REQ-034 divisor=2, 5 bits, odd parity, push 0x1F -> data 1,1,1,1,1 then parity 0; bits 5-7 of data ignored with 0xFF giving identical waveform.
REQ-035 divisor=16, frame active, push 5 words back-to-back -> 4 accepted, ready=0, fifo_level=4; frames then sent with no idle cycles between stop and start.
REQ-036 Change divisor 4 -> 8 mid-frame -> current frame stays 4 cycles/bit, next frame 8 cycles/bit.
REQ-037 Assert reset_n low mid-DATA with 2 words queued -> serial_out=1 same cycle, fifo_level=0, busy=0; no further frames after release.
